// File: rtl/im_access_ctrl.sv
// im_access_ctrl: arbitrates loader byte writes and 4-byte big-endian fetches on one byte-wide IM port.
// Optional IM_ALIGN_CHECK_EN rejects misaligned fetches with a fetch_err pulse.
module im_access_ctrl #(
  parameter int MEM_SIZE   = 128,
  parameter int AW         = 7,
  parameter int STARVE_LIM = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fetch_req,
  input  logic [31:0]   fetch_addr,
  output logic          fetch_gnt,
  output logic          fetch_valid,
  output logic [31:0]   fetch_instr,
  output logic          fetch_err,
  input  logic          ld_req,
  input  logic [31:0]   ld_addr,
  input  logic [7:0]    ld_data,
  output logic          ld_ack,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata,
  output logic          busy
);
  typedef enum logic {IDLE, FETCH} state_t;
  localparam int SW = $clog2(STARVE_LIM + 1);
  localparam logic [AW-1:0] AMASK = AW'(MEM_SIZE - 1);
  state_t state, state_nxt;
  logic [1:0] cnt;
  logic [AW-1:0] base;
  logic [23:0] acc;
  logic [SW-1:0] starve;
  logic fetch_win, misalign;
  logic unused_hi;
  assign unused_hi = ^{fetch_addr[31:AW], ld_addr[31:AW]};
`ifdef IM_ALIGN_CHECK_EN
  assign misalign = fetch_addr[1:0] != 2'b00;
`else
  assign misalign = 1'b0;
`endif
  assign busy = state == FETCH;
  assign mem_wdata = ld_data;
  assign mem_we = ld_ack;
  always_comb begin
    fetch_win = state == IDLE && fetch_req && (!ld_req || starve == SW'(STARVE_LIM));
    fetch_gnt = !rst && fetch_win;
    ld_ack = !rst && state == IDLE && ld_req && !fetch_win;
    mem_addr = state == FETCH ? (base + AW'(cnt)) & AMASK : ld_ack ? ld_addr[AW-1:0] : '0;
    state_nxt = rst ? IDLE
              : state == FETCH ? (cnt == 2'd3 ? IDLE : FETCH)
              : (fetch_gnt && !misalign) ? FETCH : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      base        <= '0;
      acc         <= '0;
      starve      <= '0;
      fetch_valid <= 1'b0;
      fetch_err   <= 1'b0;
      fetch_instr <= '0;
    end else begin
      state       <= state_nxt;
      fetch_valid <= state == FETCH && cnt == 2'd3;
      fetch_err   <= fetch_gnt && misalign;
      starve      <= (!fetch_req || fetch_gnt) ? '0 : ld_ack ? starve + SW'(1) : starve;
      if (fetch_gnt) begin
        base <= fetch_addr[AW-1:0];
        cnt  <= '0;
      end
      if (state == FETCH) begin
        cnt <= cnt + 2'd1;
        acc <= {acc[15:0], mem_rdata};
        if (cnt == 2'd3) fetch_instr <= {acc, mem_rdata};
      end
    end
  end
endmodule

// File: tb/tb_im_access_ctrl.sv
// tb_im_access_ctrl: scoreboard bench for im_access_ctrl with a behavioural byte array.
module tb_im_access_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic fetch_req = 1'b0, ld_req = 1'b0;
  logic [31:0] fetch_addr = '0, ld_addr = '0;
  logic [7:0] ld_data = '0;
  logic fetch_gnt, fetch_valid, fetch_err, ld_ack, mem_we, busy;
  logic [31:0] fetch_instr;
  logic [6:0] mem_addr;
  logic [7:0] mem_wdata, mem_rdata;
  logic [7:0] mem [128];
  logic [7:0] ref_m [128];
  typedef struct {logic [31:0] w; int c;} exp_t;
  exp_t sb[$];
  int n_vec = 0, n_err = 0, cyc = 0;

  im_access_ctrl dut (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_gnt(fetch_gnt), .fetch_valid(fetch_valid), .fetch_instr(fetch_instr),
    .fetch_err(fetch_err), .ld_req(ld_req), .ld_addr(ld_addr), .ld_data(ld_data),
    .ld_ack(ld_ack), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic misal(input logic [31:0] a);
`ifdef IM_ALIGN_CHECK_EN
    return a[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  // Reference memory follows acknowledged loader writes; expected words come from it at grant time.
  always @(negedge clk) begin : mon
    exp_t e;
    logic [6:0] a;
    if (rst) sb.delete();
    else begin
      if (fetch_valid) begin
        if (sb.size() == 0) chk("sb_unexp", 32'(sb.size()), 32'd1);
        else begin
          e = sb.pop_front();
          chk("sb_instr", fetch_instr, e.w);
          chk("sb_lat", 32'(cyc - e.c), 32'd5);
          chk("sb_err", {31'd0, fetch_err}, 32'd0);
        end
      end
      if (ld_ack) ref_m[ld_addr[6:0]] = ld_data;
      if (fetch_gnt && !misal(fetch_addr)) begin
        a = fetch_addr[6:0];
        e.w = {ref_m[a], ref_m[a + 7'd1], ref_m[a + 7'd2], ref_m[a + 7'd3]};
        e.c = cyc;
        sb.push_back(e);
      end
    end
  end

  task automatic ld(input logic [6:0] a, input logic [7:0] d);
    ld_req = 1'b1;
    ld_addr = {25'd0, a};
    ld_data = d;
    @(negedge clk);
    chk("ld_ack", {31'd0, ld_ack}, 32'd1);
    chk("ld_addr", {25'd0, mem_addr}, {25'd0, a});
    @(posedge clk) #1 ld_req = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a, output int gc);
    int i;
    fetch_req = 1'b1;
    fetch_addr = a;
    for (i = 0; i < 20; i++) begin
      @(negedge clk);
      if (fetch_gnt) break;
      @(posedge clk) #1;
    end
    gc = cyc;
    if (i == 20) chk("tmo_gnt", {31'd0, fetch_gnt}, 32'd1);
  endtask

  task automatic wait_valid();
    int i;
    for (i = 0; i < 12; i++) begin
      @(negedge clk);
      if (fetch_valid) break;
    end
    if (i == 12) chk("tmo_valid", {31'd0, fetch_valid}, 32'd1);
  endtask

  initial begin
    int g0, g1, n, nv;
    bit got;
    logic [7:0] img [8] = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04};
    logic [7:0] top [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    logic [31:0] prev;
    for (int i = 0; i < 128; i++) begin mem[i] = '0; ref_m[i] = '0; end
    fetch_req = 1'b1;
    ld_req = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_gnt", {31'd0, fetch_gnt}, 32'd0);
    chk("rst_ack", {31'd0, ld_ack}, 32'd0);
    chk("rst_we", {31'd0, mem_we}, 32'd0);
    chk("rst_valid", {31'd0, fetch_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_instr", fetch_instr, 32'd0);
    @(posedge clk) #1;
    rst = 1'b0; fetch_req = 1'b0; ld_req = 1'b0;
    for (int i = 0; i < 8; i++) ld(7'(i), img[i]);
    for (int i = 0; i < 4; i++) ld(7'(124 + i), top[i]);
    // Back-to-back fetches: the second grant coincides with the first completion.
    fetch(32'd0, g0);
    @(posedge clk) #1;
    fetch(32'd4, g1);
    chk("b2b_gap", 32'(g1 - g0), 32'd5);
    chk("b2b_instr0", fetch_instr, 32'h20080005);
    @(posedge clk) #1 fetch_req = 1'b0;
    wait_valid();
    chk("b2b_instr1", fetch_instr, 32'h8C090004);
    // Top-of-memory fetch with upper address bits set, which must be ignored.
    @(posedge clk) #1;
    fetch(32'hFFFF_FF7C, g0);
    @(posedge clk) #1 fetch_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("top_addr", {25'd0, mem_addr}, 32'(124 + i));
      chk("top_busy", {31'd0, busy}, 32'd1);
      chk("top_we", {31'd0, mem_we}, 32'd0);
    end
    @(negedge clk);
    chk("top_valid", {31'd0, fetch_valid}, 32'd1);
    chk("top_instr", fetch_instr, 32'hAABBCCDD);
    chk("top_busy_end", {31'd0, busy}, 32'd0);
`ifndef IM_ALIGN_CHECK_EN
    @(posedge clk) #1;
    fetch(32'd126, g0);
    @(posedge clk) #1 fetch_req = 1'b0;
    wait_valid();
    chk("wrap_instr", fetch_instr, 32'hCCDD2008);
`endif
    // Loader and fetch contend: loader wins until the starvation limit.
    @(posedge clk) #1;
    ld_req = 1'b1; ld_addr = 32'd64; ld_data = 8'h10;
    fetch_req = 1'b1; fetch_addr = 32'd64;
    n = 0; got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (fetch_gnt) got = 1'b1;
      else begin
        if (ld_ack) n++;
        @(posedge clk) #1;
        ld_addr = 32'(64 + n);
        ld_data = 8'(16 + n);
      end
    end
    chk("st_gnt", {31'd0, got}, 32'd1);
    chk("st_acks", 32'(n), 32'd4);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk) #1 fetch_req = 1'b0;
      @(negedge clk);
      chk("st_block", {31'd0, ld_ack}, 32'd0);
    end
    @(negedge clk);
    chk("st_valid", {31'd0, fetch_valid}, 32'd1);
    chk("st_resume", {31'd0, ld_ack}, 32'd1);
    chk("st_instr", fetch_instr, 32'h10111213);
    @(posedge clk) #1 ld_req = 1'b0;
    // Reset in the middle of a fetch discards it.
    fetch(32'd0, g0);
    @(posedge clk) #1 fetch_req = 1'b0;
    @(posedge clk) #1;
    @(posedge clk) #1 rst = 1'b1;
    @(posedge clk) #1 rst = 1'b0;
    @(negedge clk);
    chk("mrst_instr", fetch_instr, 32'd0);
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_valid", {31'd0, fetch_valid}, 32'd0);
    nv = 0;
    repeat (8) begin @(negedge clk); if (fetch_valid) nv++; end
    chk("mrst_novalid", 32'(nv), 32'd0);
`ifdef IM_ALIGN_CHECK_EN
    @(posedge clk) #1;
    fetch(32'd4, g0);
    @(posedge clk) #1 fetch_req = 1'b0;
    wait_valid();
    prev = fetch_instr;
    @(posedge clk) #1;
    fetch(32'd2, g0);
    chk("al_addr0", {31'd0, mem_addr inside {[7'd2:7'd5]}}, 32'd0);
    @(posedge clk) #1 fetch_req = 1'b0;
    @(negedge clk);
    chk("al_err", {31'd0, fetch_err}, 32'd1);
    chk("al_valid", {31'd0, fetch_valid}, 32'd0);
    chk("al_busy", {31'd0, busy}, 32'd0);
    chk("al_instr", fetch_instr, prev);
    chk("al_addr1", {31'd0, mem_addr inside {[7'd2:7'd5]}}, 32'd0);
    @(negedge clk);
    chk("al_err_clr", {31'd0, fetch_err}, 32'd0);
`else
    prev = 32'd0;
    chk("noal_err", {31'd0, fetch_err}, {31'd0, prev[0]});
`endif
    repeat (3) @(negedge clk);
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
